// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM pipeline stage: stage register, load-data wait FSM, sub-word extract, WB/forwarding.
// Optional misaligned-load exception enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_lsu #(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_hold,
  input  logic              stall_bubble,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_ld,
  input  logic [2:0]        ex_ld_op,
  input  logic              ex_rf_we,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall_req,
  output logic              wb_valid,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              fwd_we,
  output logic [RF_AW-1:0]  fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_pending,
  output logic              adel
);

  localparam int LSB = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HELD} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                valid_q, ld_q, rf_we_q;
  logic [PC_W-1:0]     pc_q;
  logic [2:0]          ld_op_q;
  logic [RF_AW-1:0]    waddr_q;
  logic [DATA_W-1:0]   result_q;

  logic                mis;
  logic                ld_act;
  logic                data_ready;
  logic                use_buf;
  logic [LSB-1:0]      lane;
  logic [DATA_W-1:0]   rdata_src;
  logic [7:0]          b_sel;
  logic [15:0]         h_sel;
  logic [31:0]         w_sel;
  logic [DATA_W-1:0]   ld_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      ld_q     <= 1'b0;
      ld_op_q  <= '0;
      rf_we_q  <= 1'b0;
      waddr_q  <= '0;
      result_q <= '0;
    end else if (stall_bubble) begin
      valid_q  <= 1'b0;
    end else if (!stall_hold) begin
      valid_q  <= ex_valid;
      pc_q     <= ex_pc;
      ld_q     <= ex_ld;
      ld_op_q  <= ex_ld_op;
      rf_we_q  <= ex_rf_we;
      waddr_q  <= ex_rf_waddr;
      result_q <= ex_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  assign lane = result_q[LSB-1:0];

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    case (ld_op_q)
      3'b010, 3'b011: mis = lane[0];
      3'b100, 3'b101: mis = |lane[1:0];
      3'b110, 3'b111: mis = |lane;
      default:        mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  assign adel   = valid_q & ld_q & mis;
  assign ld_act = valid_q & ld_q & ~mis;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    data_ready = 1'b1;
    use_buf    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (ld_act) begin
          if (dmem_rvalid) begin
            if (stall_hold) begin
              buf_d   = dmem_rdata;
              state_d = S_HELD;
            end
          end else begin
            data_ready = 1'b0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          buf_d   = dmem_rdata;
          state_d = stall_hold ? S_HELD : S_RUN;
        end else begin
          data_ready = 1'b0;
        end
      end
      S_HELD: begin
        // Data already captured; the memory bus may move on underneath us.
        use_buf = 1'b1;
        if (!stall_hold) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  assign rdata_src = use_buf ? buf_q : dmem_rdata;
  assign b_sel     = rdata_src[8*lane +: 8];
  assign h_sel     = rdata_src[16*lane[LSB-1:1] +: 16];

  generate
    if (DATA_W == 64) begin : g_w64
      assign w_sel = rdata_src[32*lane[LSB-1] +: 32];
    end else begin : g_w32
      assign w_sel = rdata_src[31:0];
    end
  endgenerate

  // On a 32-bit datapath LWU/LD collapse to LW, which is the full word either way.
  always_comb begin
    ld_data = rdata_src;
    case (ld_op_q)
      3'b000:  ld_data = DATA_W'($signed(b_sel));
      3'b001:  ld_data = DATA_W'(b_sel);
      3'b010:  ld_data = DATA_W'($signed(h_sel));
      3'b011:  ld_data = DATA_W'(h_sel);
      3'b100:  ld_data = DATA_W'($signed(w_sel));
      3'b101:  ld_data = DATA_W'(w_sel);
      default: ld_data = rdata_src;
    endcase
  end

  assign mem_stall_req = ~data_ready;
  assign fwd_pending   = ~data_ready;
  assign wb_valid      = valid_q & data_ready;
  assign wb_pc         = pc_q;
  assign wb_rf_we      = rf_we_q & ~adel;
  assign wb_rf_waddr   = waddr_q;
  assign wb_rf_wdata   = ld_q ? ld_data : result_q;
  assign fwd_we        = wb_valid & wb_rf_we;
  assign fwd_waddr     = waddr_q;
  assign fwd_wdata     = wb_rf_wdata;

endmodule
